// File: rtl/i_decode.sv
// Instruction decode stage: 32x32 register file with optional write-through,
// opcode decode into control bits, immediate sign extension and the
// ID/EX pipeline latch. A sticky flag records any unsupported opcode.
module i_decode #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [31:0] nPC,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] ex_nPC,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [5:0]  ex_funct,
  output logic        ex_RegWrite,
  output logic        ex_MemtoReg,
  output logic        ex_Branch,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_RegDst,
  output logic        ex_ALUSrc,
  output logic [1:0]  ex_ALUOp,
  output logic        illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  logic [31:0] regs_q [32];

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [5:0]  opcode;
  logic        bubble;
  logic        wb_en;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;

  logic        dec_RegWrite;
  logic        dec_MemtoReg;
  logic        dec_Branch;
  logic        dec_MemRead;
  logic        dec_MemWrite;
  logic        dec_RegDst;
  logic        dec_ALUSrc;
  logic [1:0]  dec_ALUOp;
  logic        dec_illegal;

  logic [31:0] ex_nPC_q, ex_rd1_q, ex_rd2_q, ex_imm_q;
  logic [4:0]  ex_rt_q, ex_rd_q;
  logic [5:0]  ex_funct_q;
  logic        ex_RegWrite_q, ex_MemtoReg_q, ex_Branch_q, ex_MemRead_q;
  logic        ex_MemWrite_q, ex_RegDst_q, ex_ALUSrc_q;
  logic [1:0]  ex_ALUOp_q;
  logic        illegal_q;

  // Register 0 is hard-wired to zero; a same-cycle write is forwarded
  // only when write-through is enabled.
  function automatic logic [31:0] read_port(
    input logic [4:0]  addr,
    input logic [31:0] stored,
    input logic        we,
    input logic [4:0]  waddr,
    input logic [31:0] wdata
  );
    logic [31:0] val;
    if (addr == 5'd0) begin
      val = 32'd0;
    end else if (BYPASS && we && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  assign rs     = IR[25:21];
  assign rt     = IR[20:16];
  assign opcode = IR[31:26];
  assign bubble = stall | flush;
  assign wb_en  = wb_RegWrite && (wb_addr != 5'd0);
  assign rd1    = read_port(rs, regs_q[rs], wb_en, wb_addr, wb_data);
  assign rd2    = read_port(rt, regs_q[rt], wb_en, wb_addr, wb_data);
  assign imm    = {{16{IR[15]}}, IR[15:0]};

  // Opcode to control-bit decode; unknown opcodes produce all zeros.
  always_comb begin
    dec_RegWrite = 1'b0;
    dec_MemtoReg = 1'b0;
    dec_Branch   = 1'b0;
    dec_MemRead  = 1'b0;
    dec_MemWrite = 1'b0;
    dec_RegDst   = 1'b0;
    dec_ALUSrc   = 1'b0;
    dec_ALUOp    = 2'b00;
    dec_illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_RegWrite = 1'b1;
        dec_RegDst   = 1'b1;
        dec_ALUOp    = 2'b10;
      end
      OP_LW: begin
        dec_RegWrite = 1'b1;
        dec_MemtoReg = 1'b1;
        dec_MemRead  = 1'b1;
        dec_ALUSrc   = 1'b1;
      end
      OP_SW: begin
        dec_MemWrite = 1'b1;
        dec_ALUSrc   = 1'b1;
      end
      OP_BEQ: begin
        dec_Branch   = 1'b1;
        dec_ALUOp    = 2'b01;
      end
      OP_ADDI: begin
        dec_RegWrite = 1'b1;
        dec_ALUSrc   = 1'b1;
      end
      default: begin
        dec_illegal  = 1'b1;
      end
    endcase
  end

  // Register file write port; reset clears every entry and drops any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (wb_en) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // ID/EX latch: data always advances, control is zeroed on a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_nPC_q      <= 32'd0;
      ex_rd1_q      <= 32'd0;
      ex_rd2_q      <= 32'd0;
      ex_imm_q      <= 32'd0;
      ex_rt_q       <= 5'd0;
      ex_rd_q       <= 5'd0;
      ex_funct_q    <= 6'd0;
      ex_RegWrite_q <= 1'b0;
      ex_MemtoReg_q <= 1'b0;
      ex_Branch_q   <= 1'b0;
      ex_MemRead_q  <= 1'b0;
      ex_MemWrite_q <= 1'b0;
      ex_RegDst_q   <= 1'b0;
      ex_ALUSrc_q   <= 1'b0;
      ex_ALUOp_q    <= 2'b00;
      illegal_q     <= 1'b0;
    end else begin
      ex_nPC_q      <= nPC;
      ex_rd1_q      <= rd1;
      ex_rd2_q      <= rd2;
      ex_imm_q      <= imm;
      ex_rt_q       <= IR[20:16];
      ex_rd_q       <= IR[15:11];
      ex_funct_q    <= IR[5:0];
      ex_RegWrite_q <= dec_RegWrite & ~bubble;
      ex_MemtoReg_q <= dec_MemtoReg & ~bubble;
      ex_Branch_q   <= dec_Branch   & ~bubble;
      ex_MemRead_q  <= dec_MemRead  & ~bubble;
      ex_MemWrite_q <= dec_MemWrite & ~bubble;
      ex_RegDst_q   <= dec_RegDst   & ~bubble;
      ex_ALUSrc_q   <= dec_ALUSrc   & ~bubble;
      ex_ALUOp_q    <= bubble ? 2'b00 : dec_ALUOp;
      illegal_q     <= illegal_q | (dec_illegal & ~bubble);
    end
  end

  assign ex_nPC      = ex_nPC_q;
  assign ex_rd1      = ex_rd1_q;
  assign ex_rd2      = ex_rd2_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rt       = ex_rt_q;
  assign ex_rd       = ex_rd_q;
  assign ex_funct    = ex_funct_q;
  assign ex_RegWrite = ex_RegWrite_q;
  assign ex_MemtoReg = ex_MemtoReg_q;
  assign ex_Branch   = ex_Branch_q;
  assign ex_MemRead  = ex_MemRead_q;
  assign ex_MemWrite = ex_MemWrite_q;
  assign ex_RegDst   = ex_RegDst_q;
  assign ex_ALUSrc   = ex_ALUSrc_q;
  assign ex_ALUOp    = ex_ALUOp_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: two instances (write-through on and off) share inputs
// and are compared each cycle against a behavioural model, plus literal
// expectations for the worked examples.
module tb_i_decode;

  logic        clk = 1'b0;
  logic        reset, stall, flush, wb_RegWrite;
  logic [31:0] IR, nPC, wb_data;
  logic [4:0]  wb_addr;

  // Index 1: write-through instance, index 0: no write-through.
  logic [31:0] o_nPC [2];
  logic [31:0] o_rd1 [2];
  logic [31:0] o_rd2 [2];
  logic [31:0] o_imm [2];
  logic [4:0]  o_rt [2];
  logic [4:0]  o_rd [2];
  logic [5:0]  o_funct [2];
  logic        o_RegWrite [2], o_MemtoReg [2], o_Branch [2], o_MemRead [2];
  logic        o_MemWrite [2], o_RegDst [2], o_ALUSrc [2], o_ill [2];
  logic [1:0]  o_ALUOp [2];

  int errors = 0;
  int checks = 0;

  // Model state and expectations.
  logic [31:0] m_regs [32];
  logic        m_ill;
  logic [31:0] e_nPC, e_imm;
  logic [31:0] e_rd1 [2];
  logic [31:0] e_rd2 [2];
  logic [4:0]  e_rt, e_rd;
  logic [5:0]  e_funct;
  logic [8:0]  e_ctrl;

  always #5 clk = ~clk;

  i_decode #(.BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .IR(IR), .nPC(nPC), .stall(stall), .flush(flush),
    .wb_RegWrite(wb_RegWrite), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_nPC(o_nPC[1]), .ex_rd1(o_rd1[1]), .ex_rd2(o_rd2[1]), .ex_imm(o_imm[1]),
    .ex_rt(o_rt[1]), .ex_rd(o_rd[1]), .ex_funct(o_funct[1]),
    .ex_RegWrite(o_RegWrite[1]), .ex_MemtoReg(o_MemtoReg[1]), .ex_Branch(o_Branch[1]),
    .ex_MemRead(o_MemRead[1]), .ex_MemWrite(o_MemWrite[1]), .ex_RegDst(o_RegDst[1]),
    .ex_ALUSrc(o_ALUSrc[1]), .ex_ALUOp(o_ALUOp[1]), .illegal(o_ill[1])
  );

  i_decode #(.BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .IR(IR), .nPC(nPC), .stall(stall), .flush(flush),
    .wb_RegWrite(wb_RegWrite), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_nPC(o_nPC[0]), .ex_rd1(o_rd1[0]), .ex_rd2(o_rd2[0]), .ex_imm(o_imm[0]),
    .ex_rt(o_rt[0]), .ex_rd(o_rd[0]), .ex_funct(o_funct[0]),
    .ex_RegWrite(o_RegWrite[0]), .ex_MemtoReg(o_MemtoReg[0]), .ex_Branch(o_Branch[0]),
    .ex_MemRead(o_MemRead[0]), .ex_MemWrite(o_MemWrite[0]), .ex_RegDst(o_RegDst[0]),
    .ex_ALUSrc(o_ALUSrc[0]), .ex_ALUOp(o_ALUOp[0]), .illegal(o_ill[0])
  );

  // Control table: {RegWrite,MemtoReg,Branch,MemRead,MemWrite,RegDst,ALUSrc,ALUOp}.
  function automatic logic [9:0] ref_decode(input logic [5:0] op);
    case (op)
      6'h00:   return {1'b0, 9'b1_0_0_0_0_1_0_10};
      6'h23:   return {1'b0, 9'b1_1_0_1_0_0_1_00};
      6'h2B:   return {1'b0, 9'b0_0_0_0_1_0_1_00};
      6'h04:   return {1'b0, 9'b0_0_1_0_0_0_0_01};
      6'h08:   return {1'b0, 9'b1_0_0_0_0_0_1_00};
      default: return {1'b1, 9'b0};
    endcase
  endfunction

  function automatic logic [8:0] act_ctrl(input int b);
    return {o_RegWrite[b], o_MemtoReg[b], o_Branch[b], o_MemRead[b],
            o_MemWrite[b], o_RegDst[b], o_ALUSrc[b], o_ALUOp[b]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare both instances against the model expectation.
  task automatic compare_all();
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("nPC[%0d]", b),   o_nPC[b], e_nPC);
      chk($sformatf("rd1[%0d]", b),   o_rd1[b], e_rd1[b]);
      chk($sformatf("rd2[%0d]", b),   o_rd2[b], e_rd2[b]);
      chk($sformatf("imm[%0d]", b),   o_imm[b], e_imm);
      chk($sformatf("rt[%0d]", b),    {27'd0, o_rt[b]}, {27'd0, e_rt});
      chk($sformatf("rd[%0d]", b),    {27'd0, o_rd[b]}, {27'd0, e_rd});
      chk($sformatf("funct[%0d]", b), {26'd0, o_funct[b]}, {26'd0, e_funct});
      chk($sformatf("ctrl[%0d]", b),  {23'd0, act_ctrl(b)}, {23'd0, e_ctrl});
      chk($sformatf("illegal[%0d]", b), {31'd0, o_ill[b]}, {31'd0, m_ill});
    end
  endtask

  // Apply one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input logic rst, input logic [31:0] ir, input logic [31:0] npc,
                      input logic st, input logic fl, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    logic [9:0] d;
    logic [4:0] s, t;
    logic       wr;
    reset = rst; IR = ir; nPC = npc; stall = st; flush = fl;
    wb_RegWrite = we; wb_addr = wa; wb_data = wd;
    s  = ir[25:21];
    t  = ir[20:16];
    wr = we && (wa != 5'd0);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_ill = 1'b0;
      e_nPC = 0; e_imm = 0; e_rt = 0; e_rd = 0; e_funct = 0; e_ctrl = 0;
      for (int b = 0; b < 2; b++) begin e_rd1[b] = 0; e_rd2[b] = 0; end
    end else begin
      d       = ref_decode(ir[31:26]);
      e_nPC   = npc;
      e_imm   = {{16{ir[15]}}, ir[15:0]};
      e_rt    = ir[20:16];
      e_rd    = ir[15:11];
      e_funct = ir[5:0];
      e_ctrl  = (st || fl) ? 9'd0 : d[8:0];
      if (!(st || fl) && d[9]) m_ill = 1'b1;
      e_rd1[0] = (s == 0) ? 32'd0 : m_regs[s];
      e_rd2[0] = (t == 0) ? 32'd0 : m_regs[t];
      e_rd1[1] = (wr && wa == s && s != 0) ? wd : e_rd1[0];
      e_rd2[1] = (wr && wa == t && t != 0) ? wd : e_rd2[0];
      if (wr) m_regs[wa] = wd;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  logic [31:0] rir;
  logic [5:0]  ops [5];

  initial begin
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h08;
    reset = 1'b1; IR = 0; nPC = 0; stall = 0; flush = 0;
    wb_RegWrite = 0; wb_addr = 0; wb_data = 0;
    @(negedge clk);

    step(1, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0);
    chk("reset_ill", {31'd0, o_ill[1]}, 32'd0);
    chk("reset_rw", {31'd0, o_RegWrite[1]}, 32'd0);

    // Preload $9=5, $10=7 then decode add $8,$9,$10.
    step(0, 32'h0, 32'h1, 0, 0, 1, 5'd9, 32'd5);
    step(0, 32'h0, 32'h2, 0, 0, 1, 5'd10, 32'd7);
    step(0, 32'h012A4020, 32'h3, 0, 0, 0, 5'd0, 32'h0);
    chk("add_rd1", o_rd1[1], 32'd5);
    chk("add_rd2", o_rd2[1], 32'd7);
    chk("add_rd", {27'd0, o_rd[1]}, 32'd8);
    chk("add_rw", {31'd0, o_RegWrite[1]}, 32'd1);
    chk("add_regdst", {31'd0, o_RegDst[1]}, 32'd1);
    chk("add_aluop", {30'd0, o_ALUOp[1]}, 32'd2);
    chk("add_npc", o_nPC[1], 32'h3);

    step(0, 32'h8D09FFFC, 32'h4, 0, 0, 0, 5'd0, 32'h0);
    chk("lw_imm", o_imm[1], 32'hFFFFFFFC);
    chk("lw_memread", {31'd0, o_MemRead[1]}, 32'd1);
    chk("lw_memtoreg", {31'd0, o_MemtoReg[1]}, 32'd1);
    chk("lw_alusrc", {31'd0, o_ALUSrc[1]}, 32'd1);
    chk("lw_rt", {27'd0, o_rt[1]}, 32'd9);

    // Same-cycle write/read of $9.
    step(0, 32'h012A4020, 32'h5, 0, 0, 1, 5'd9, 32'hDEADBEEF);
    chk("byp1_rd1", o_rd1[1], 32'hDEADBEEF);
    chk("byp0_rd1", o_rd0_or(0), 32'd5);
    step(0, 32'h012A4020, 32'h6, 0, 0, 0, 5'd0, 32'h0);
    chk("byp0_next", o_rd1[0], 32'hDEADBEEF);

    // Write to $0 is discarded, same-cycle read of $0 gives 0.
    step(0, 32'h0, 32'h7, 0, 0, 1, 5'd0, 32'h1234);
    chk("r0_same1", o_rd1[1], 32'd0);
    chk("r0_same0", o_rd1[0], 32'd0);
    step(0, 32'h0, 32'h8, 0, 0, 0, 5'd0, 32'h0);
    chk("r0_after", o_rd2[1], 32'd0);

    // Bubbles.
    step(0, 32'hAD090004, 32'h9, 1, 0, 0, 5'd0, 32'h0);
    chk("stall_ctrl", {23'd0, act_ctrl(1)}, 32'd0);
    chk("stall_imm", o_imm[1], 32'h4);
    step(0, 32'h11090003, 32'hA, 0, 1, 0, 5'd0, 32'h0);
    chk("flush_branch", {31'd0, o_Branch[1]}, 32'd0);
    step(0, 32'hFC000000, 32'hB, 1, 1, 0, 5'd0, 32'h0);
    chk("bubble_ill", {31'd0, o_ill[1]}, 32'd0);

    // Illegal opcode is sticky.
    step(0, 32'hFC000000, 32'hC, 0, 0, 0, 5'd0, 32'h0);
    chk("ill_set", {31'd0, o_ill[1]}, 32'd1);
    chk("ill_ctrl", {23'd0, act_ctrl(1)}, 32'd0);
    step(0, 32'h012A4020, 32'hD, 0, 0, 0, 5'd0, 32'h0);
    chk("ill_sticky", {31'd0, o_ill[0]}, 32'd1);
    step(1, 32'h012A4020, 32'hE, 0, 0, 1, 5'd9, 32'h55);
    chk("ill_reset", {31'd0, o_ill[1]}, 32'd0);
    step(0, 32'h012A4020, 32'hF, 0, 0, 0, 5'd0, 32'h0);
    chk("reset_dropped_wb", o_rd1[1], 32'd0);

    // Randomized traffic with narrow register ranges to force collisions.
    for (int n = 0; n < 400; n++) begin
      rir = $urandom;
      if ($urandom_range(0, 5) != 0) rir[31:26] = ops[$urandom_range(0, 4)];
      rir[25:21] = 5'($urandom_range(0, 7));
      rir[20:16] = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 59) == 0), rir, $urandom,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [31:0] o_rd0_or(input int b);
    return o_rd1[b];
  endfunction

endmodule

// File: doc/i_decode.md
# i_decode

Instruction decode stage: consumes the instruction word and incremented PC produced by the fetch stage, reads a 32 x 32-bit register file, decodes the MIPS opcode into control bits, sign-extends the immediate, and registers everything into the ID/EX pipeline latch. Sits between the fetch stage and the execute stage. The register-file write port is driven by the write-back stage.

## Interface
- BYPASS, 1: 1 = a read of the register being written this cycle returns the write data; 0 = it returns the old contents.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- IR  input  32  instruction word from fetch.
- nPC  input  32  PC+1 from fetch.
- stall  input  1  insert a bubble into ID/EX (hazard unit).
- flush  input  1  insert a bubble into ID/EX (taken branch).
- wb_RegWrite  input  1  write-back enable.
- wb_addr  input  5  write-back register number.
- wb_data  input  32  write-back data.
- ex_nPC  output  32  registered nPC.
- ex_rd1, ex_rd2  output  32 each  registered register contents for rs and rt.
- ex_imm  output  32  registered sign-extended IR[15:0].
- ex_rt, ex_rd  output  5 each  registered IR[20:16] and IR[15:11].
- ex_funct  output  6  registered IR[5:0].
- ex_RegWrite, ex_MemtoReg, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegDst, ex_ALUSrc  output  1 each  registered control bits.
- ex_ALUOp  output  2  registered ALU operation class.
- illegal  output  1  sticky flag: an unsupported opcode was decoded.

## Operation
- Register file: 32 entries x 32 bits. Register 0 always reads 0, and writes to it are discarded. A write occurs on the clock edge when wb_RegWrite=1 and wb_addr!=0. Writes proceed regardless of stall or flush.
- Reads are combinational on rs=IR[25:21] and rt=IR[20:16], bypassed per BYPASS. They feed the ID/EX latch.
- Decode by IR[31:26]. Each opcode lists the control bits set to 1; all others are 0.
  - 0x00 R-type: RegWrite, RegDst; ALUOp=10.
  - 0x23 lw: RegWrite, MemtoReg, MemRead, ALUSrc; ALUOp=00.
  - 0x2B sw: MemWrite, ALUSrc; ALUOp=00.
  - 0x04 beq: Branch; ALUOp=01.
  - 0x08 addi: RegWrite, ALUSrc; ALUOp=00.
  - Any other opcode: all control bits 0, ALUOp=00, and illegal is set.
- Immediate: ex_imm = {16{IR[15]}, IR[15:0]}.
- Bubble (stall=1 or flush=1): all ex_ control bits and ex_ALUOp are latched as 0. Data fields (ex_nPC, ex_rd1, ex_rd2, ex_imm, ex_rt, ex_rd, ex_funct) latch normally. An illegal opcode is not flagged during a bubble.
- illegal stays set until reset.

## Timing
- Latency: IR/nPC in cycle N appear on the ex_ outputs after the edge ending cycle N (1 cycle).
- Reset (edge with reset=1):
  - All 32 registers cleared to 0.
  - All ex_ outputs cleared to 0.
  - illegal cleared to 0.
  - Reset takes priority over stall, flush and write-back. Reset asserted mid-stream discards the in-flight instruction and any write-back in that cycle.
- stall and flush together behave as a single bubble.
- Write and read of the same register in the same cycle:
  - BYPASS=1: ex_rd1/ex_rd2 latch wb_data.
  - BYPASS=0: they latch the old value; the new value is visible from the next cycle.
- Write to register 0 with same-cycle read of register 0: output is 0 for either BYPASS setting.

## Test plan
- Reset then decode IR=0x012A4020 (add $8,$9,$10) with $9=5, $10=7 preloaded via write-back -> next cycle ex_rd1=5, ex_rd2=7, ex_rd=8, ex_RegWrite=1, ex_RegDst=1, ex_ALUOp=10.
- IR=0x8D09FFFC (lw $9,-4($8)) -> ex_imm=0xFFFFFFFC, ex_MemRead=1, ex_MemtoReg=1, ex_ALUSrc=1, ex_rt=9.
- Same-cycle write of $9=0xDEADBEEF while decoding a read of $9:
  - BYPASS=1 -> ex_rd1=0xDEADBEEF.
  - BYPASS=0 -> old value; 0xDEADBEEF on the next decode.
- wb_addr=0, wb_data=0x1234, then read $0 -> 0.
- stall=1 during sw 0xAD090004 -> all ex_ control bits 0, ex_imm=0x4. flush=1 during beq -> ex_Branch=0.
- IR=0xFC000000 -> illegal=1, control bits 0. illegal stays 1 through subsequent legal instructions and clears only on reset.
